// File: rtl/mrsc_encode_writer_if.sv
// Handshake bundle for the MRSC encode writer: upstream data valid/ready plus the
// downstream memory write request/acknowledge.
interface mrsc_encode_writer_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic [0:15]       in_data;
  logic              in_ready;
  logic [0:31]       inj_mask;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [0:31]       mem_wdata;
  logic              mem_ack;

  modport slave (
    input  in_valid, in_data, inj_mask, mem_ack,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_data, inj_mask, mem_ack,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mrsc_encode_writer.sv
// Encodes 16-bit words into 32-bit MRSC codewords and writes them to sequential
// memory addresses, with optional per-word error injection.
module mrsc_encode_writer #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int INJ_EN = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clear,
  mrsc_encode_writer_if.slave  bus,
  output logic [ADDR_W:0]      o_wr_count,
  output logic                 o_full
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_accept;
  logic              w_done;
  logic              r_in_ready;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [0:31]       r_mem_wdata;
  logic [ADDR_W:0]   r_wr_count;
  logic              r_full;
  logic [0:31]       w_codeword;
  logic [0:31]       w_inj;

  // s[r][c] = d[4c+r]; bit 0 of d is the MSB of the word.
  function automatic logic [0:15] mrsc_check(input logic [0:15] d);
    logic [0:15] c;
    c[0]  = d[0]  ^ d[5]  ^ d[2]  ^ d[7];
    c[1]  = d[12] ^ d[9]  ^ d[14] ^ d[11];
    c[2]  = d[4]  ^ d[1]  ^ d[6]  ^ d[3];
    c[3]  = d[8]  ^ d[13] ^ d[10] ^ d[15];
    c[4]  = ^d[0:3];
    c[5]  = ^d[12:15];
    c[6]  = ^d[4:7];
    c[7]  = ^d[8:11];
    c[8]  = d[0]  ^ d[8];
    c[9]  = d[4]  ^ d[12];
    c[10] = d[1]  ^ d[9];
    c[11] = d[5]  ^ d[13];
    c[12] = d[2]  ^ d[10];
    c[13] = d[6]  ^ d[14];
    c[14] = d[3]  ^ d[11];
    c[15] = d[7]  ^ d[15];
    return c;
  endfunction

  assign w_codeword = {bus.in_data, mrsc_check(bus.in_data)};
  assign w_inj      = (INJ_EN != 0) ? bus.inj_mask : 32'h0000_0000;

  // Next-state and transfer strobes; ready is registered so accept needs no comb path to valid.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid && r_in_ready) begin
          w_state_nxt = ST_WRITE;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (bus.mem_ack) begin
          w_state_nxt = ST_IDLE;
          w_done      = 1'b1;
        end else begin
          w_state_nxt = ST_WRITE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register; clear overrides any accept or ack in the same cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else if (i_clear) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Write datapath, address/count bookkeeping and the registered ready.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_in_ready  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'h0000_0000;
      r_wr_count  <= '0;
      r_full      <= 1'b0;
    end else if (i_clear) begin
      r_in_ready  <= 1'b1;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'h0000_0000;
      r_wr_count  <= '0;
      r_full      <= 1'b0;
    end else if (w_accept) begin
      r_in_ready  <= 1'b0;
      r_mem_we    <= 1'b1;
      r_mem_wdata <= w_codeword ^ w_inj;
    end else if (w_done) begin
      r_mem_we   <= 1'b0;
      r_wr_count <= r_wr_count + (ADDR_W+1)'(1);
      if (r_mem_addr == LAST_ADDR) begin
        r_full     <= 1'b1;
        r_in_ready <= 1'b0;
      end else begin
        r_mem_addr <= r_mem_addr + ADDR_W'(1);
        r_in_ready <= 1'b1;
      end
    end else begin
      r_in_ready <= (r_state == ST_IDLE) && !r_full;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign o_wr_count    = r_wr_count;
  assign o_full        = r_full;

endmodule

// File: tb/tb_mrsc_encode_writer.sv
// Directed bench: a DEPTH=4 injecting writer plus an INJ_EN=0 twin driven in lockstep.
module tb_mrsc_encode_writer;

  logic clk;
  logic rst_n;
  logic clear;
  int   n_checks;
  int   n_errors;

  logic [8:0] a_count;
  logic       a_full;
  logic [8:0] b_count;
  logic       b_full;

  mrsc_encode_writer_if #(.ADDR_W(8)) a_if ();
  mrsc_encode_writer_if #(.ADDR_W(8)) b_if ();

  mrsc_encode_writer #(.ADDR_W(8), .DEPTH(4), .INJ_EN(1)) u_dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_clear    (clear),
    .bus        (a_if.slave),
    .o_wr_count (a_count),
    .o_full     (a_full)
  );

  mrsc_encode_writer #(.ADDR_W(8), .DEPTH(256), .INJ_EN(0)) u_noinj (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_clear    (clear),
    .bus        (b_if.slave),
    .o_wr_count (b_count),
    .o_full     (b_full)
  );

  assign b_if.in_valid = a_if.in_valid;
  assign b_if.in_data  = a_if.in_data;
  assign b_if.inj_mask = a_if.inj_mask;
  assign b_if.mem_ack  = a_if.mem_ack;

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic [31:0] m);
    a_if.in_valid = 1'b1;
    a_if.in_data  = d;
    a_if.inj_mask = m;
    step();
    a_if.in_valid = 1'b0;
  endtask

  task automatic ack();
    a_if.mem_ack = 1'b1;
    step();
    a_if.mem_ack = 1'b0;
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    clear = 1'b0;
    n_checks = 0;
    n_errors = 0;
    a_if.in_valid = 1'b0;
    a_if.in_data  = 16'h0000;
    a_if.inj_mask = 32'h0000_0000;
    a_if.mem_ack  = 1'b0;
    step();
    step();
    check_val("rst_we",    32'(a_if.mem_we),    32'h0);
    check_val("rst_addr",  32'(a_if.mem_addr),  32'h0);
    check_val("rst_wdata", a_if.mem_wdata,      32'h0);
    check_val("rst_count", 32'(a_count),        32'h0);
    check_val("rst_full",  32'(a_full),         32'h0);
    check_val("rst_ready", 32'(a_if.in_ready),  32'h0);
    rst_n = 1'b1;
    step();
    check_val("ready_after_rst", 32'(a_if.in_ready), 32'h1);

    // T1
    send(16'h0000, 32'h0000_0000);
    check_val("t1_we",    32'(a_if.mem_we),   32'h1);
    check_val("t1_addr",  32'(a_if.mem_addr), 32'h0);
    check_val("t1_wdata", a_if.mem_wdata,     32'h0000_0000);
    check_val("t1_ready", 32'(a_if.in_ready), 32'h0);
    ack();
    check_val("t1_we_off", 32'(a_if.mem_we),   32'h0);
    check_val("t1_count",  32'(a_count),       32'h1);
    check_val("t1_addr1",  32'(a_if.mem_addr), 32'h1);

    // T2 + T4: fill the DEPTH=4 writer back to back
    send(16'hFFFF, 32'h0000_0000);
    check_val("t2_ffff", a_if.mem_wdata, 32'hFFFF_0000);
    ack();
    send(16'h8000, 32'h0000_0000);
    check_val("t2_8000",      a_if.mem_wdata,     32'h8000_8880);
    check_val("t2_8000_addr", 32'(a_if.mem_addr), 32'h2);
    ack();
    send(16'h4000, 32'h0000_0000);
    check_val("t2_4000",      a_if.mem_wdata,     32'h4000_2820);
    check_val("t2_4000_addr", 32'(a_if.mem_addr), 32'h3);
    ack();
    check_val("t4_full",  32'(a_full),          32'h1);
    check_val("t4_count", 32'(a_count),         32'h4);
    check_val("t4_addr",  32'(a_if.mem_addr),   32'h3);
    check_val("t4_ready", 32'(a_if.in_ready),   32'h0);
    a_if.in_valid = 1'b1;
    a_if.in_data  = 16'h1111;
    step();
    step();
    a_if.in_valid = 1'b0;
    check_val("t4_5th_we",    32'(a_if.mem_we), 32'h0);
    check_val("t4_5th_count", 32'(a_count),     32'h4);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_val("t4_clr_full",  32'(a_full),        32'h0);
    check_val("t4_clr_addr",  32'(a_if.mem_addr), 32'h0);
    check_val("t4_clr_count", 32'(a_count),       32'h0);
    check_val("t4_clr_ready", 32'(a_if.in_ready), 32'h1);

    // T3: stall the ack for 5 cycles
    send(16'h0001, 32'h0000_0000);
    for (int i = 0; i < 5; i++) begin
      check_val("t3_we",    32'(a_if.mem_we),   32'h1);
      check_val("t3_addr",  32'(a_if.mem_addr), 32'h0);
      check_val("t3_wdata", a_if.mem_wdata,     32'h0001_1401);
      check_val("t3_ready", 32'(a_if.in_ready), 32'h0);
      step();
    end
    // ack together with a new valid: word waits for IDLE
    a_if.in_valid = 1'b1;
    a_if.in_data  = 16'h8000;
    a_if.inj_mask = 32'h0000_8000;
    a_if.mem_ack  = 1'b1;
    step();
    a_if.mem_ack = 1'b0;
    check_val("t3_we_off", 32'(a_if.mem_we),   32'h0);
    check_val("t3_addr1",  32'(a_if.mem_addr), 32'h1);
    check_val("t3_count",  32'(a_count),       32'h1);
    check_val("t3_ready1", 32'(a_if.in_ready), 32'h1);
    step();
    a_if.in_valid = 1'b0;
    // T5
    check_val("t5_we",    32'(a_if.mem_we), 32'h1);
    check_val("t5_inj",   a_if.mem_wdata,   32'h8000_0880);
    check_val("t5_noinj", b_if.mem_wdata,   32'h8000_8880);
    ack();
    a_if.inj_mask = 32'h0000_0000;
    check_val("t5_count", 32'(a_count), 32'h2);

    // T6: clear with ack during WRITE
    send(16'h4000, 32'h0000_0000);
    clear = 1'b1;
    a_if.mem_ack = 1'b1;
    step();
    clear = 1'b0;
    a_if.mem_ack = 1'b0;
    check_val("t6_clr_we",    32'(a_if.mem_we),   32'h0);
    check_val("t6_clr_count", 32'(a_count),       32'h0);
    check_val("t6_clr_addr",  32'(a_if.mem_addr), 32'h0);
    check_val("t6_clr_wdata", a_if.mem_wdata,     32'h0);
    // reset during WRITE
    send(16'hFFFF, 32'h0000_0000);
    check_val("t6_pre_we", 32'(a_if.mem_we), 32'h1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_val("t6_rst_we",    32'(a_if.mem_we),   32'h0);
    check_val("t6_rst_count", 32'(a_count),       32'h0);
    check_val("t6_rst_ready", 32'(a_if.in_ready), 32'h0);
    step();
    check_val("t6_ready_back", 32'(a_if.in_ready), 32'h1);
    // stray ack while idle
    a_if.mem_ack = 1'b1;
    step();
    a_if.mem_ack = 1'b0;
    check_val("stray_ack_count", 32'(a_count),       32'h0);
    check_val("stray_ack_addr",  32'(a_if.mem_addr), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
